// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture
//   Receive-side counterpart of the PWM generator. Samples an external PWM
//   pin, measures the high time and the period between successive rising
//   edges, and reports the duty cycle as an integer percentage 0-100. This
//   is the same 8-bit encoding the generator takes as its duty input.
//
// Parameters
//   CNT_W   : width of the period / high-time / timeout counters (cycles)
//   TIMEOUT : cycles without a rising edge before a static-level result
//             is reported (must be < 2**CNT_W)
//   FILT_N  : consecutive identical samples needed by the glitch filter
//
// Build option
//   PWM_CAP_FILTER_EN : when defined, a glitch filter sits after the
//                       synchronizer. All edge detection and counting then
//                       use the filtered level. This adds FILT_N cycles of
//                       edge latency.
//
// Ports
//   I_clk        : system clock
//   I_rst_n      : asynchronous active-low reset
//   I_en         : capture enable, active high
//   I_PWM        : asynchronous PWM pin
//   O_PWM_percen : last measured duty, 0-100
//   O_valid      : one-cycle pulse when O_PWM_percen is updated
//   O_busy       : high while the divider is iterating

module pwm_duty_capture #(
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 2_000_000,
  parameter int FILT_N  = 4
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_en,
  input  logic       I_PWM,
  output logic [7:0] O_PWM_percen,
  output logic       O_valid,
  output logic       O_busy
);

  // The dividend Hl*100 needs 7 more bits than the counters.
  localparam int DW = CNT_W + 7;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [DW-1:0]    HUNDRED  = DW'(100);

  typedef enum logic {
    ST_IDLE,
    ST_MEAS
  } state_e;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic             s_level;
  logic             rise;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] t_cnt_q, t_cnt_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             timeout_hit;

  logic [DW-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0] den_q, den_d;
  logic [6:0]       quo_q, quo_d;
  logic [2:0]       bit_q, bit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DW-1:0]    div_trial;

  logic [7:0]       pct_q, pct_d;
  logic             valid_q, valid_d;

`ifdef PWM_CAP_FILTER_EN
  localparam int FILT_CW = (FILT_N > 1) ? $clog2(FILT_N) : 1;
  localparam logic [FILT_CW-1:0] FILT_LAST = FILT_CW'(FILT_N - 1);
  localparam logic [FILT_CW-1:0] FILT_ONE  = {{(FILT_CW-1){1'b0}}, 1'b1};

  logic               filt_q, filt_d;
  logic [FILT_CW-1:0] filt_cnt_q, filt_cnt_d;

  // The filtered level flips only after FILT_N consecutive samples that
  // disagree with it. Any agreeing sample restarts the run.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_d = sync2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FILT_ONE;
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign s_level = filt_q;
`else
  // FILT_N only matters to the filtered build. A value below 1 is never
  // meaningful, so this empty block marks that case in elaboration.
  if (FILT_N < 1) begin : g_filt_n_invalid
  end

  assign s_level = sync2_q;
`endif

  assign rise      = s_level & ~prev_q;
  assign div_trial = {7'b0, den_q} << bit_q;

  // Next-state logic for the synchronizer, measurement FSM, timeout
  // watchdog, restoring divider and output registers.
  always_comb begin
    sync1_d     = I_PWM;
    sync2_d     = sync1_q;
    prev_d      = s_level;
    state_d     = state_q;
    t_cnt_d     = t_cnt_q;
    h_cnt_d     = h_cnt_q;
    to_cnt_d    = to_cnt_q;
    timeout_hit = 1'b0;
    rem_d       = rem_q;
    den_d       = den_q;
    quo_d       = quo_q;
    bit_d       = bit_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pct_d       = pct_q;
    valid_d     = 1'b0;

    if (!I_en) begin
      state_d  = ST_IDLE;
      t_cnt_d  = '0;
      h_cnt_d  = '0;
      to_cnt_d = '0;
      rem_d    = '0;
      den_d    = '0;
      quo_d    = '0;
      bit_d    = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end else begin
      // The watchdog saturates at TIMEOUT, so it fires once and stays
      // quiet until a rising edge re-arms it.
      if (rise) begin
        to_cnt_d = '0;
      end else if (to_cnt_q != TO_LIMIT) begin
        to_cnt_d = to_cnt_q + CNT_ONE;
        if (to_cnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
        end
      end

      // One quotient bit per cycle, MSB first. The quotient never exceeds
      // 100 because Hl <= Tl, so 7 bits are enough.
      if (busy_q) begin
        if (rem_q >= div_trial) begin
          rem_d        = rem_q - div_trial;
          quo_d[bit_q] = 1'b1;
        end
        if (bit_q == 3'd0) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          bit_d = bit_q - 3'd1;
        end
      end

      if (done_q) begin
        pct_d   = (quo_q > 7'd100) ? 8'd100 : {1'b0, quo_q};
        valid_d = 1'b1;
        done_d  = 1'b0;
      end

      // The rising-edge cycle itself counts as the first high cycle of the
      // new period, which is why both counters restart at 1.
      case (state_q)
        ST_IDLE: begin
          t_cnt_d = '0;
          h_cnt_d = '0;
          if (rise) begin
            t_cnt_d = CNT_ONE;
            h_cnt_d = CNT_ONE;
            state_d = ST_MEAS;
          end
        end
        ST_MEAS: begin
          if (rise) begin
            t_cnt_d = CNT_ONE;
            h_cnt_d = CNT_ONE;
            // A period that ends while the divider still iterates is
            // dropped. The new period is already being counted.
            if (!busy_q) begin
              rem_d  = DW'(h_cnt_q) * HUNDRED;
              den_d  = t_cnt_q;
              quo_d  = '0;
              bit_d  = 3'd6;
              busy_d = 1'b1;
            end
          end else begin
            if (t_cnt_q != CNT_MAX) begin
              t_cnt_d = t_cnt_q + CNT_ONE;
            end
            if (s_level && (h_cnt_q != CNT_MAX)) begin
              h_cnt_d = h_cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // A static pin overrides everything: report 0 or 100 and start over.
      if (timeout_hit) begin
        pct_d   = s_level ? 8'd100 : 8'd0;
        valid_d = 1'b1;
        state_d = ST_IDLE;
        t_cnt_d = '0;
        h_cnt_d = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      state_q  <= ST_IDLE;
      t_cnt_q  <= '0;
      h_cnt_q  <= '0;
      to_cnt_q <= '0;
      rem_q    <= '0;
      den_q    <= '0;
      quo_q    <= '0;
      bit_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pct_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      t_cnt_q  <= t_cnt_d;
      h_cnt_q  <= h_cnt_d;
      to_cnt_q <= to_cnt_d;
      rem_q    <= rem_d;
      den_q    <= den_d;
      quo_q    <= quo_d;
      bit_q    <= bit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pct_q    <= pct_d;
      valid_q  <= valid_d;
    end
  end

  assign O_PWM_percen = pct_q;
  assign O_valid      = valid_q;
  assign O_busy       = busy_q;

endmodule
